// File: rtl/sha2_unpadding.sv
// rtl/sha2_unpadding.sv - SHA-2 padding remover: validates padding, re-emits the original message bits
module sha2_unpadding #(
    parameter int WIDTH = 32,
    parameter int MODE  = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH):0]   out_bits,
    output logic                     out_last,
    output logic [2*WIDTH-1:0]       length_out,
    output logic                     done,
    output logic                     error
);
    localparam int BLOCK = (MODE == 384 || MODE == 512) ? 1024 : 512;
    localparam int LB    = $clog2(BLOCK);
    localparam int LW    = $clog2(WIDTH);
    localparam int OBW   = $clog2(WIDTH) + 1;
    localparam int PW    = 2 * WIDTH + 2;

    typedef enum logic [2:0] {S_FILL, S_CHECK, S_DRAIN_HELD, S_DRAIN_FINAL, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] bank [2][16];
    logic             wb, held, trunc;
    logic [3:0]       w, d;
    logic [4:0]       c;
    logic [31:0]      n;

    // Bit positions are global message offsets, MSB of word 0 of block 0 is position 0
    logic [PW-1:0]    lval, lim, need, cbit, p, dbit, rem;
    logic [31:0]      cblk, dblk;
    logic [WIDTH-1:0] cw, dw, odata;
    logic [OBW-1:0]   obits;
    logic             chk_err, emit_ok, olast, chk_held;

    always_comb begin
        lval     = PW'(length_out);
        lim      = (PW'(n) << LB) - PW'(2 * WIDTH);
        need     = (lval + PW'(2 * WIDTH + BLOCK)) >> LB;
        chk_held = held && !c[4];
        cblk     = chk_held ? n - 32'd2 : n - 32'd1;
        cw       = chk_held ? bank[~wb][c[3:0]] : bank[wb][c[3:0]];
        cbit     = PW'({cblk, c[3:0]}) << LW;
        p        = '0;
        chk_err  = (c == 5'd0) && (need != PW'(n));
        for (int j = 0; j < WIDTH; j++) begin
            p = cbit + PW'(j);
            if (p == lval && !cw[WIDTH-1-j])
                chk_err = 1'b1;
            if (p > lval && p < lim && cw[WIDTH-1-j])
                chk_err = 1'b1;
        end
    end

    // Without truncation (mid-message held drain) every word goes out whole
    always_comb begin
        dblk    = (state == S_DRAIN_HELD) ? n - 32'd2 : n - 32'd1;
        dw      = (state == S_DRAIN_HELD) ? bank[~wb][d] : bank[wb][d];
        dbit    = PW'({dblk, d}) << LW;
        rem     = lval - dbit;
        emit_ok = !trunc || (dbit < lval);
        obits   = (!trunc || rem >= PW'(WIDTH)) ? OBW'(WIDTH) : rem[OBW-1:0];
        odata   = dw & ~({WIDTH{1'b1}} >> obits);
        olast   = trunc && (dbit + PW'(WIDTH) >= lval);
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready)
            bank[wb][w] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FILL;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_bits   <= '0;
            out_last   <= 1'b0;
            length_out <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            wb         <= 1'b0;
            held       <= 1'b0;
            trunc      <= 1'b0;
            w          <= '0;
            d          <= '0;
            c          <= '0;
            n          <= '0;
        end else begin
            done <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                S_FILL: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (w == 4'd0 && n == 32'd0) begin
                            error      <= 1'b0;
                            length_out <= '0;
                        end
                        w <= w + 4'd1;
                        if (w == 4'd15) begin
                            n <= n + 32'd1;
                            if (in_last) begin
                                length_out <= {bank[wb][14], in_data};
                                c          <= '0;
                                in_ready   <= 1'b0;
                                state      <= S_CHECK;
                            end else if (held) begin
                                trunc    <= 1'b0;
                                d        <= '0;
                                in_ready <= 1'b0;
                                state    <= S_DRAIN_HELD;
                            end else begin
                                wb   <= ~wb;
                                held <= 1'b1;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    error <= error | chk_err;
                    c     <= c + 5'd1;
                    if (c == (held ? 5'd31 : 5'd15)) begin
                        if (error || chk_err || length_out == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            trunc <= 1'b1;
                            d     <= '0;
                            state <= held ? S_DRAIN_HELD : S_DRAIN_FINAL;
                        end
                    end
                end
                S_DRAIN_HELD, S_DRAIN_FINAL: begin
                    if (!out_valid || out_ready) begin
                        if (emit_ok) begin
                            out_valid <= 1'b1;
                            out_data  <= odata;
                            out_bits  <= obits;
                            out_last  <= olast;
                            d         <= d + 4'd1;
                            if (d == 4'd15 && state == S_DRAIN_HELD) begin
                                if (trunc) begin
                                    state <= S_DRAIN_FINAL;
                                end else begin
                                    wb       <= ~wb;
                                    in_ready <= 1'b1;
                                    state    <= S_FILL;
                                end
                            end
                        end else begin
                            // Last word has left the output register; nothing further qualifies
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    n        <= '0;
                    w        <= '0;
                    held     <= 1'b0;
                    trunc    <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= S_FILL;
                end
                default: state <= S_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_sha2_unpadding.sv
// tb/tb_sha2_unpadding.sv - scoreboard bench for sha2_unpadding (SHA-256 configuration)
module tb_sha2_unpadding;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last, done, error;
    logic [31:0] in_data, out_data;
    logic [5:0]  out_bits;
    logic [63:0] length_out;

    sha2_unpadding #(.WIDTH(32), .MODE(256)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bits(out_bits), .out_last(out_last), .length_out(length_out), .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic [5:0] b; logic l; } exp_t;
    typedef struct { logic e; logic [63:0] len; } done_t;

    exp_t        exp_q[$];
    done_t       done_q[$];
    logic [31:0] mw [0:63];
    int          n_cmp = 0, n_mis = 0, cyc = 0, done_cnt = 0, done_cyc = 0, rmode = 0;
    logic        stall = 1'b0;
    logic [31:0] sd;
    logic [5:0]  sb;
    logic        sl;
    exp_t        me;
    done_t       md;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(sd));
                check("stall_bits", 64'(out_bits), 64'(sb));
                check("stall_last", 64'(out_last), 64'(sl));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_out", 64'd1, 64'd0);
                end else begin
                    me = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(me.d));
                    check("out_bits", 64'(out_bits), 64'(me.b));
                    check("out_last", 64'(out_last), 64'(me.l));
                end
            end
            stall = out_valid && !out_ready;
            sd = out_data; sb = out_bits; sl = out_last;
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
                if (done_q.size() == 0) begin
                    check("extra_done", 64'd1, 64'd0);
                end else begin
                    md = done_q.pop_front();
                    check("error", 64'(error), 64'(md.e));
                    check("length_out", length_out, md.len);
                    check("drained", 64'(exp_q.size()), 64'd0);
                end
            end
        end
    end

    task automatic fill_mw();
        for (int i = 0; i < 64; i++) mw[i] = $urandom;
    endtask

    // corrupt: 0 none, 1 clear marker bit, 2 length word forced to 0x300
    task automatic run_msg(input int len, input int corrupt, input int exp_lat,
                           input bit glitch, input bit rst_mid);
        logic [31:0] pa [0:63];
        logic [31:0] m;
        int nb, nw, nout, b, t, t0, dc0;
        exp_t e;
        done_t dr;
        nb = (len + 576) / 512;
        nw = nb * 16;
        nout = (len + 31) / 32;
        for (int i = 0; i < 64; i++) pa[i] = '0;
        for (int g = 0; g < nout; g++) begin
            b = (len - 32 * g > 32) ? 32 : len - 32 * g;
            m = 32'hFFFF_FFFF >> b;
            pa[g] = mw[g] & ~m;
            if (corrupt == 0) begin
                e.d = pa[g]; e.b = 6'(b); e.l = (g == nout - 1);
                exp_q.push_back(e);
            end
        end
        pa[len / 32][31 - (len % 32)] = 1'b1;
        pa[nw - 2] = '0;
        pa[nw - 1] = 32'(len);
        if (corrupt == 1) pa[len / 32][31 - (len % 32)] = 1'b0;
        if (corrupt == 2) pa[15] = 32'h300;
        dr.e = (corrupt != 0);
        dr.len = (corrupt == 2) ? 64'h300 : 64'(len);
        done_q.push_back(dr);
        dc0 = done_cnt;
        for (int i = 0; i < nw; i++) begin
            in_valid = 1'b1;
            in_data = pa[i];
            in_last = (i == nw - 1) || (glitch && i == 3);
            t = 0;
            while (!in_ready && t < 2000) begin @(negedge clk); t++; end
            if (t >= 2000) begin check("in_ready_timeout", 64'd0, 64'd1); break; end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        t0 = cyc;
        if (rst_mid) begin
            t = 0;
            while (!out_valid && t < 200) begin @(negedge clk); t++; end
            check("drain_started", 64'(out_valid), 64'd1);
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_error", 64'(error), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd0);
            check("rst_length", length_out, 64'd0);
            exp_q.delete();
            done_q.delete();
            rmode = 0;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
        end else begin
            t = 0;
            while (done_cnt == dc0 && t < 4000) begin @(negedge clk); t++; end
            check("done_seen", 64'(done_cnt != dc0), 64'd1);
            if (exp_lat >= 0) check("done_latency", 64'(done_cyc - t0), 64'(exp_lat));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_bits", 64'(out_bits), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_length", length_out, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_rise", 64'(in_ready), 64'd1);

        fill_mw(); mw[0] = 32'h6162_6300;
        run_msg(24, 0, 18, 1'b0, 1'b0);
        fill_mw();
        run_msg(448, 0, -1, 1'b0, 1'b0);
        run_msg(0, 0, 16, 1'b0, 1'b0);
        mw[0] = 32'h6162_6300;
        run_msg(24, 1, 16, 1'b0, 1'b0);
        run_msg(24, 2, 16, 1'b0, 1'b0);
        fill_mw(); rmode = 1;
        run_msg(1000, 0, -1, 1'b1, 1'b0);
        fill_mw();
        run_msg(447, 0, -1, 1'b0, 1'b0);
        rmode = 0;
        fill_mw(); rmode = 2;
        run_msg(200, 0, -1, 1'b0, 1'b1);
        fill_mw(); mw[0] = 32'h6162_6300;
        run_msg(24, 0, 18, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
